iso_tu_scheduler_mc: RTL and testbench
======================================

Name: iso_tu_scheduler_mc

Overview:
- Parametrised next-generation isochronous scheduler for the DisplayPort main-link transmit path. It merges the timing-decision and scheduler functions into one block.
- It sequences each frame through active-line, horizontal-blank and vertical-blank periods, one symbol slot per lane per clock.
- It splits active periods into transfer units (TUs). Each TU carries valid data or stuffing. The valid size per TU is set by a fractional accumulator, replacing fixed alternate-up/down counts.
- Lane count and TU geometry are parameters. Lane enables are a vector, not fixed per-lane ports.

Parameters:
MAX_LANES, 4, number of physical lanes; legal values 1, 2, 4, 8.
TU_SIZE, 64, symbols per TU per lane; range 32..64.
CTR_W, 16, width of all horizontal and vertical counters and config fields.
FRAC_W, 8, width of the fractional valid-size field.

Ports:
clk  in  1  symbol clock.
rst  in  1  synchronous, active-high reset.
cfg_vld  in  1  start request; sampled only in IDLE.
cfg_lane_count  in  4  active lanes; legal values 1, 2, 4, up to MAX_LANES.
cfg_tu_vld_int  in  7  integer part of valid symbols per TU.
cfg_tu_vld_frac  in  FRAC_W  fractional part of valid symbols per TU, in units of 2^-FRAC_W.
cfg_h_active  in  CTR_W  active symbols per lane per line.
cfg_h_blank  in  CTR_W  blank symbols per lane per line; minimum 2.
cfg_v_active  in  CTR_W  active lines per frame; minimum 1.
cfg_v_blank  in  CTR_W  blank lines per frame; 0 allowed.
stop  in  1  stop request; honoured at frame end.
cfg_err  out  1  one-cycle pulse when cfg_vld carries an illegal configuration.
sched_state  out  2  current state: 0 IDLE, 1 H_ACTIVE, 2 H_BLANK, 3 V_BLANK.
sched_stream_en  out  MAX_LANES  per-lane valid-data slot.
sched_stuff_en  out  MAX_LANES  per-lane stuffing slot.
sched_blank_en  out  MAX_LANES  per-lane blanking slot.
sched_bs  out  1  blank-start slot; first symbol of any blank line or H_BLANK period.
sched_be  out  1  blank-end slot; last H_BLANK symbol before an active line.
sched_vblank_id  out  1  high during V_BLANK.
sched_line_cnt  out  CTR_W  line index within the frame, active lines then blank lines.
frame_done  out  1  one-cycle pulse on the last symbol of a frame.

Behaviour:
- Reset: state IDLE, all outputs 0, accumulator 0, counters 0. Reset asserted mid-frame forces the same result on the next edge; no partial line completes.
- All outputs are registered. Lane bits at index >= cfg_lane_count are always 0.
- IDLE: cfg_vld high in cycle 0 with a legal config latches all cfg_* fields. Cycle 1 presents the first H_ACTIVE symbol of line 0.
  - Illegal config means any of: lane count not 1/2/4 or above MAX_LANES; cfg_h_blank < 2; cfg_v_active = 0; cfg_h_active = 0.
  - On an illegal config, cfg_err pulses in cycle 1 and the block stays in IDLE.
- cfg_vld outside IDLE is ignored. The latched config is stable for the whole run.
- H_ACTIVE lasts cfg_h_active cycles.
  - At the start of each TU, the block computes {carry, acc} = acc + frac.
  - The TU valid count N = int + carry, saturated to TU_SIZE.
  - The first N slots of the TU assert stream_en; the remaining TU_SIZE-N slots assert stuff_en.
  - The accumulator clears at the start of every active line.
  - The last TU is truncated at the end of H_ACTIVE: stream slots come first, then stuffing.
  - If N = 0, the TU is all stuffing.
- H_BLANK lasts cfg_h_blank cycles. blank_en is high throughout. sched_bs fires on cycle 0 and sched_be on the last cycle.
  - If the next line is active, the next state is H_ACTIVE with line_cnt+1.
  - On the last active line, sched_be is suppressed and the next state is V_BLANK.
- V_BLANK lasts cfg_v_blank × (cfg_h_active + cfg_h_blank) cycles. vblank_id and blank_en are high throughout.
  - sched_bs fires at the start of each blank line. sched_be fires on the final cycle of the final blank line.
  - line_cnt increments per blank line.
- Frame end is the last V_BLANK cycle, or the last H_BLANK cycle when cfg_v_blank = 0.
  - frame_done pulses on that cycle and line_cnt wraps to 0.
  - If cfg_v_blank = 0, sched_be is not suppressed on the last active line; the block goes directly to H_ACTIVE of the next frame.
  - If stop was seen at any time in the frame, the next state is IDLE; otherwise the next frame starts.
- Simultaneous stop and frame end: the stop is honoured at that same frame end.
- Exactly one of stream/stuff/blank is high per enabled lane in every non-IDLE cycle.

Test Plan:
- lane_count=4, int=40, frac=128, h_active=256, TU_SIZE=64 -> TU valid counts 40,41,40,41; 162 stream and 94 stuff cycles per line; bits [3:0] only.
- h_active=100, int=70 with TU_SIZE=64 -> first TU 64 stream/0 stuff (saturated); truncated second TU 36 stream.
- v_active=2, v_blank=1, h_active=8, h_blank=4 -> state sequence A8 B4 A8 B4 V12; bs on cycles 8, 20, 24; be on cycles 11 and 35; no be on cycle 23; frame_done on cycle 35.
- cfg_lane_count=3 or cfg_h_blank=1 -> cfg_err pulse in cycle 1; state remains 0; all enables 0.
- stop asserted mid-line 0 -> the frame completes, frame_done pulses, and the next cycle is IDLE with all outputs 0.
- rst asserted during H_ACTIVE -> next cycle all outputs 0, state IDLE; a new cfg_vld restarts at line 0 with a cleared accumulator.

Source files
------------

// File: rtl/iso_tu_scheduler_mc.sv
// Isochronous TU scheduler for the DisplayPort main-link transmit path.
// Walks each frame through active lines, horizontal blanking and vertical
// blanking, one symbol slot per lane per clock. Active periods are cut into
// transfer units whose valid size comes from a fractional accumulator.
//
// state    | meaning
// IDLE     | waiting for cfg_vld; all outputs 0
// H_ACTIVE | active symbols of a line; each TU is stream slots, then stuffing
// H_BLANK  | horizontal blanking after every active line
// V_BLANK  | blank lines at the end of the frame
module iso_tu_scheduler_mc #(
  parameter int MAX_LANES = 4,
  parameter int TU_SIZE   = 64,
  parameter int CTR_W     = 16,
  parameter int FRAC_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_vld,
  input  logic [3:0]           cfg_lane_count,
  input  logic [6:0]           cfg_tu_vld_int,
  input  logic [FRAC_W-1:0]    cfg_tu_vld_frac,
  input  logic [CTR_W-1:0]     cfg_h_active,
  input  logic [CTR_W-1:0]     cfg_h_blank,
  input  logic [CTR_W-1:0]     cfg_v_active,
  input  logic [CTR_W-1:0]     cfg_v_blank,
  input  logic                 stop,
  output logic                 cfg_err,
  output logic [1:0]           sched_state,
  output logic [MAX_LANES-1:0] sched_stream_en,
  output logic [MAX_LANES-1:0] sched_stuff_en,
  output logic [MAX_LANES-1:0] sched_blank_en,
  output logic                 sched_bs,
  output logic                 sched_be,
  output logic                 sched_vblank_id,
  output logic [CTR_W-1:0]     sched_line_cnt,
  output logic                 frame_done
);

  localparam int TU_W  = $clog2(TU_SIZE);
  localparam int VLD_W = $clog2(TU_SIZE + 1);
  localparam logic [CTR_W-1:0] ONE     = 1;
  localparam logic [CTR_W-1:0] TWO     = 2;
  localparam logic [CTR_W:0]   ONE_X   = 1;
  localparam logic [TU_W-1:0]  TU_ONE  = 1;
  localparam logic [TU_W-1:0]  TU_LAST = TU_W'(TU_SIZE - 1);
  localparam logic [VLD_W-1:0] VLD_ONE = 1;
  localparam logic [VLD_W-1:0] TU_FULL = VLD_W'(TU_SIZE);
  localparam logic [7:0]       N_MAX   = 8'(TU_SIZE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    H_ACTIVE = 2'd1,
    H_BLANK  = 2'd2,
    V_BLANK  = 2'd3
  } state_t;

  // Registers describe the slot currently on the outputs; *_n is the next slot.
  state_t            st, st_n;
  logic [CTR_W-1:0]  cnt, cnt_n;         // slots left in the period after this one
  logic [CTR_W-1:0]  line, line_n;
  logic [TU_W-1:0]   tu_rem, tu_rem_n;   // slots left in the TU after this one
  logic [VLD_W-1:0]  vld_rem, vld_rem_n; // stream slots still owed in this TU
  logic [FRAC_W-1:0] acc, acc_n;
  logic              stop_seen, stop_seen_n;

  logic [3:0]        lanes_q, lanes_e;
  logic [6:0]        int_q, int_e;
  logic [FRAC_W-1:0] frac_q, frac_e;
  logic [CTR_W-1:0]  ha_q, ha_e, hb_q, hb_e, va_q, va_e, vb_q, vb_e;

  logic              lane_ok, cfg_legal, start_ok;
  logic [MAX_LANES-1:0] lane_mask;
  logic [CTR_W-1:0]  line_len_m1;
  logic [CTR_W:0]    lines_e;

  logic              new_line, frame_end, stream_n;
  logic [FRAC_W-1:0] acc_base;
  logic [FRAC_W:0]   tu_sum;
  logic [7:0]        n_raw;
  logic [VLD_W-1:0]  vld_cur;
  logic              last_act_n, last_vb_n, hb_end_n, vb_end_n;
  logic              bs_n, be_n, fd_n;

  // Legal lane counts are powers of two that fit the physical lanes.
  always_comb begin
    case (cfg_lane_count)
      4'd1, 4'd2, 4'd4, 4'd8: lane_ok = (int'(cfg_lane_count) <= MAX_LANES);
      default:                lane_ok = 1'b0;
    endcase
  end

  assign cfg_legal = lane_ok && (cfg_h_blank >= TWO) && (cfg_v_active != '0) &&
                     (cfg_h_active != '0);
  assign start_ok  = (st == IDLE) && cfg_vld && cfg_legal;

  // Live inputs drive the first slot while IDLE; latched copies thereafter.
  always_comb begin
    if (st == IDLE) begin
      lanes_e = cfg_lane_count;
      int_e   = cfg_tu_vld_int;
      frac_e  = cfg_tu_vld_frac;
      ha_e    = cfg_h_active;
      hb_e    = cfg_h_blank;
      va_e    = cfg_v_active;
      vb_e    = cfg_v_blank;
    end else begin
      lanes_e = lanes_q;
      int_e   = int_q;
      frac_e  = frac_q;
      ha_e    = ha_q;
      hb_e    = hb_q;
      va_e    = va_q;
      vb_e    = vb_q;
    end
  end

  assign line_len_m1 = ha_e + hb_e - ONE;
  assign lines_e     = {1'b0, va_e} + {1'b0, vb_e};

  // Lanes at or above the configured count never carry a slot.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < MAX_LANES; i++) lane_mask[i] = (i < int'(lanes_e));
  end

  // Next-slot computation: period sequencing, frame end, then TU content.
  always_comb begin
    st_n        = st;
    cnt_n       = cnt;
    line_n      = line;
    tu_rem_n    = tu_rem;
    vld_rem_n   = vld_rem;
    acc_n       = acc;
    stop_seen_n = stop_seen | stop;
    new_line    = 1'b0;
    frame_end   = 1'b0;
    acc_base    = '0;
    tu_sum      = '0;
    n_raw       = '0;
    vld_cur     = '0;
    stream_n    = 1'b0;

    case (st)
      IDLE: begin
        stop_seen_n = 1'b0;
        if (start_ok) begin
          st_n     = H_ACTIVE;
          cnt_n    = ha_e - ONE;
          line_n   = '0;
          new_line = 1'b1;
        end
      end
      H_ACTIVE: begin
        if (cnt != '0) begin
          cnt_n = cnt - ONE;
        end else begin
          st_n  = H_BLANK;
          cnt_n = hb_e - ONE;
        end
      end
      H_BLANK: begin
        if (cnt != '0) begin
          cnt_n = cnt - ONE;
        end else if (line == va_e - ONE) begin
          if (vb_e == '0) begin
            frame_end = 1'b1;
          end else begin
            st_n   = V_BLANK;
            line_n = line + ONE;
            cnt_n  = line_len_m1;
          end
        end else begin
          st_n     = H_ACTIVE;
          line_n   = line + ONE;
          cnt_n    = ha_e - ONE;
          new_line = 1'b1;
        end
      end
      V_BLANK: begin
        if (cnt != '0) begin
          cnt_n = cnt - ONE;
        end else if ({1'b0, line} == lines_e - ONE_X) begin
          frame_end = 1'b1;
        end else begin
          line_n = line + ONE;
          cnt_n  = line_len_m1;
        end
      end
      default: st_n = IDLE;
    endcase

    // A stop seen anywhere in the frame, including its last slot, ends the run here.
    if (frame_end) begin
      line_n      = '0;
      stop_seen_n = 1'b0;
      if (stop_seen || stop) begin
        st_n  = IDLE;
        cnt_n = '0;
      end else begin
        st_n     = H_ACTIVE;
        cnt_n    = ha_e - ONE;
        new_line = 1'b1;
      end
    end

    // TU boundaries restart at every active line, so the last TU simply truncates.
    if (st_n == H_ACTIVE) begin
      if (new_line || (tu_rem == '0)) begin
        acc_base = new_line ? '0 : acc;
        tu_sum   = {1'b0, acc_base} + {1'b0, frac_e};
        acc_n    = tu_sum[FRAC_W-1:0];
        n_raw    = {1'b0, int_e} + {7'd0, tu_sum[FRAC_W]};
        vld_cur  = (n_raw > N_MAX) ? TU_FULL : n_raw[VLD_W-1:0];
        tu_rem_n = TU_LAST;
      end else begin
        vld_cur  = vld_rem;
        tu_rem_n = tu_rem - TU_ONE;
      end
      stream_n  = (vld_cur != '0);
      vld_rem_n = stream_n ? vld_cur - VLD_ONE : vld_cur;
    end else begin
      tu_rem_n  = '0;
      vld_rem_n = '0;
      if (st_n == IDLE) acc_n = '0;
    end
  end

  assign last_act_n = (line_n == va_e - ONE);
  assign last_vb_n  = ({1'b0, line_n} == lines_e - ONE_X);
  assign hb_end_n   = (st_n == H_BLANK) && (cnt_n == '0);
  assign vb_end_n   = (st_n == V_BLANK) && (cnt_n == '0);
  assign bs_n       = ((st_n == H_BLANK) && (cnt_n == hb_e - ONE)) ||
                      ((st_n == V_BLANK) && (cnt_n == line_len_m1));
  assign be_n       = (hb_end_n && (!last_act_n || (vb_e == '0))) || (vb_end_n && last_vb_n);
  assign fd_n       = (hb_end_n && last_act_n && (vb_e == '0)) || (vb_end_n && last_vb_n);

  // Configuration register: captured once per run on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
      int_q   <= '0;
      frac_q  <= '0;
      ha_q    <= '0;
      hb_q    <= '0;
      va_q    <= '0;
      vb_q    <= '0;
    end else if (start_ok) begin
      lanes_q <= cfg_lane_count;
      int_q   <= cfg_tu_vld_int;
      frac_q  <= cfg_tu_vld_frac;
      ha_q    <= cfg_h_active;
      hb_q    <= cfg_h_blank;
      va_q    <= cfg_v_active;
      vb_q    <= cfg_v_blank;
    end
  end

  // Scheduler state and registered slot outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= IDLE;
      cnt             <= '0;
      line            <= '0;
      tu_rem          <= '0;
      vld_rem         <= '0;
      acc             <= '0;
      stop_seen       <= 1'b0;
      cfg_err         <= 1'b0;
      sched_state     <= 2'd0;
      sched_stream_en <= '0;
      sched_stuff_en  <= '0;
      sched_blank_en  <= '0;
      sched_bs        <= 1'b0;
      sched_be        <= 1'b0;
      sched_vblank_id <= 1'b0;
      sched_line_cnt  <= '0;
      frame_done      <= 1'b0;
    end else begin
      st              <= st_n;
      cnt             <= cnt_n;
      line            <= line_n;
      tu_rem          <= tu_rem_n;
      vld_rem         <= vld_rem_n;
      acc             <= acc_n;
      stop_seen       <= stop_seen_n;
      cfg_err         <= (st == IDLE) && cfg_vld && !cfg_legal;
      sched_state     <= st_n;
      sched_stream_en <= ((st_n == H_ACTIVE) && stream_n) ? lane_mask : '0;
      sched_stuff_en  <= ((st_n == H_ACTIVE) && !stream_n) ? lane_mask : '0;
      sched_blank_en  <= ((st_n == H_BLANK) || (st_n == V_BLANK)) ? lane_mask : '0;
      sched_bs        <= bs_n;
      sched_be        <= be_n;
      sched_vblank_id <= (st_n == V_BLANK);
      sched_line_cnt  <= line_n;
      frame_done      <= fd_n;
    end
  end

endmodule

// File: tb/tb_iso_tu_scheduler_mc.sv
// Bench for iso_tu_scheduler_mc: every slot is compared with a frame-position
// model (line/column arithmetic, TU valid counts from floor division).
module tb_iso_tu_scheduler_mc;

  localparam int MAX_LANES = 4;
  localparam int TU_SIZE   = 64;
  localparam int CTR_W     = 16;
  localparam int FRAC_W    = 8;
  localparam int RUN_LIMIT = 4000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_vld;
  logic [3:0]           cfg_lane_count;
  logic [6:0]           cfg_tu_vld_int;
  logic [FRAC_W-1:0]    cfg_tu_vld_frac;
  logic [CTR_W-1:0]     cfg_h_active;
  logic [CTR_W-1:0]     cfg_h_blank;
  logic [CTR_W-1:0]     cfg_v_active;
  logic [CTR_W-1:0]     cfg_v_blank;
  logic                 stop;
  logic                 cfg_err;
  logic [1:0]           sched_state;
  logic [MAX_LANES-1:0] sched_stream_en;
  logic [MAX_LANES-1:0] sched_stuff_en;
  logic [MAX_LANES-1:0] sched_blank_en;
  logic                 sched_bs;
  logic                 sched_be;
  logic                 sched_vblank_id;
  logic [CTR_W-1:0]     sched_line_cnt;
  logic                 frame_done;

  always #5 clk = ~clk;

  iso_tu_scheduler_mc #(
    .MAX_LANES(MAX_LANES),
    .TU_SIZE  (TU_SIZE),
    .CTR_W    (CTR_W),
    .FRAC_W   (FRAC_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_vld        (cfg_vld),
    .cfg_lane_count (cfg_lane_count),
    .cfg_tu_vld_int (cfg_tu_vld_int),
    .cfg_tu_vld_frac(cfg_tu_vld_frac),
    .cfg_h_active   (cfg_h_active),
    .cfg_h_blank    (cfg_h_blank),
    .cfg_v_active   (cfg_v_active),
    .cfg_v_blank    (cfg_v_blank),
    .stop           (stop),
    .cfg_err        (cfg_err),
    .sched_state    (sched_state),
    .sched_stream_en(sched_stream_en),
    .sched_stuff_en (sched_stuff_en),
    .sched_blank_en (sched_blank_en),
    .sched_bs       (sched_bs),
    .sched_be       (sched_be),
    .sched_vblank_id(sched_vblank_id),
    .sched_line_cnt (sched_line_cnt),
    .frame_done     (frame_done)
  );

  int checks = 0;
  int errors = 0;

  int m_lanes, m_int, m_frac, m_ha, m_hb, m_va, m_vb;

  int                   e_state;
  logic [MAX_LANES-1:0] e_stream, e_stuff, e_blank;
  logic                 e_bs, e_be, e_vb, e_fd, e_fe;
  int                   e_line;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Valid symbols of TU j: integer part plus the carries the fraction produces by that TU.
  function automatic int tu_valid(input int j);
    int carry;
    int n;
    carry = (((j + 1) * m_frac) >> FRAC_W) - ((j * m_frac) >> FRAC_W);
    n = m_int + carry;
    return (n > TU_SIZE) ? TU_SIZE : n;
  endfunction

  // Expected outputs for slot k counted from the first active symbol of the run.
  task automatic model(input int k);
    int ll, fl, p, ln, col;
    logic [MAX_LANES-1:0] mask;
    ll = m_ha + m_hb;
    fl = (m_va + m_vb) * ll;
    p = k % fl;
    ln = p / ll;
    col = p % ll;
    mask = '0;
    for (int i = 0; i < MAX_LANES; i++) mask[i] = (i < m_lanes);
    e_stream = '0; e_stuff = '0; e_blank = '0;
    e_bs = 1'b0; e_be = 1'b0; e_vb = 1'b0; e_fd = 1'b0;
    e_line = ln;
    e_fe = (p == fl - 1);
    if (ln < m_va && col < m_ha) begin
      e_state = 1;
      if ((col % TU_SIZE) < tu_valid(col / TU_SIZE)) e_stream = mask;
      else e_stuff = mask;
    end else if (ln < m_va) begin
      e_state = 2;
      e_blank = mask;
      e_bs = (col == m_ha);
      e_be = (col == ll - 1) && (ln != m_va - 1 || m_vb == 0);
      e_fd = (col == ll - 1) && (ln == m_va - 1) && (m_vb == 0);
    end else begin
      e_state = 3;
      e_blank = mask;
      e_vb = 1'b1;
      e_bs = (col == 0);
      e_be = (col == ll - 1) && (ln == m_va + m_vb - 1);
      e_fd = e_be;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"},  sched_state, 0);
    chk({tag, "_stream"}, sched_stream_en, 0);
    chk({tag, "_stuff"},  sched_stuff_en, 0);
    chk({tag, "_blank"},  sched_blank_en, 0);
    chk({tag, "_bs"},     sched_bs, 0);
    chk({tag, "_be"},     sched_be, 0);
    chk({tag, "_vbid"},   sched_vblank_id, 0);
    chk({tag, "_line"},   sched_line_cnt, 0);
    chk({tag, "_fdone"},  frame_done, 0);
    chk({tag, "_err"},    cfg_err, 0);
  endtask

  // One run: start, compare every slot, stop or reset at the given slot (-1 = never).
  task automatic run(input int lanes, input int vint, input int frac, input int ha,
                     input int hb, input int va, input int vb, input int stop_k,
                     input int rst_k, output int s_cnt, output int f_cnt);
    int k;
    bit done;
    bit seen;
    m_lanes = lanes; m_int = vint; m_frac = frac;
    m_ha = ha; m_hb = hb; m_va = va; m_vb = vb;
    s_cnt = 0; f_cnt = 0; k = 0; done = 1'b0; seen = 1'b0;
    cfg_lane_count  = 4'(lanes);
    cfg_tu_vld_int  = 7'(vint);
    cfg_tu_vld_frac = FRAC_W'(frac);
    cfg_h_active    = CTR_W'(ha);
    cfg_h_blank     = CTR_W'(hb);
    cfg_v_active    = CTR_W'(va);
    cfg_v_blank     = CTR_W'(vb);
    cfg_vld = 1'b1;
    @(posedge clk); #1;
    cfg_vld = 1'b0;
    while (!done && k < RUN_LIMIT) begin
      model(k);
      chk("state",  sched_state, 64'(e_state));
      chk("stream", sched_stream_en, e_stream);
      chk("stuff",  sched_stuff_en, e_stuff);
      chk("blank",  sched_blank_en, e_blank);
      chk("bs",     sched_bs, e_bs);
      chk("be",     sched_be, e_be);
      chk("vbid",   sched_vblank_id, e_vb);
      chk("line",   sched_line_cnt, 64'(e_line));
      chk("fdone",  frame_done, e_fd);
      chk("err",    cfg_err, 0);
      if (k < ha) begin
        if (sched_stream_en[0]) s_cnt++;
        if (sched_stuff_en[0]) f_cnt++;
      end
      stop = (k == stop_k);
      if (stop) seen = 1'b1;
      if (k == rst_k) begin
        rst = 1'b1; cfg_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; stop = 1'b0;
        check_idle("rst");
        done = 1'b1;
      end else if (e_fe && seen) begin
        cfg_vld = 1'b0;
        @(posedge clk); #1;
        stop = 1'b0;
        check_idle("end");
        done = 1'b1;
      end else begin
        cfg_vld         = 1'($urandom_range(0, 1));
        cfg_lane_count  = 4'($urandom);
        cfg_tu_vld_int  = 7'($urandom);
        cfg_tu_vld_frac = FRAC_W'($urandom);
        cfg_h_active    = CTR_W'($urandom_range(0, 40));
        cfg_h_blank     = CTR_W'($urandom_range(0, 9));
        cfg_v_active    = CTR_W'($urandom_range(0, 3));
        cfg_v_blank     = CTR_W'($urandom_range(0, 3));
        @(posedge clk); #1;
        stop = 1'b0;
        k++;
      end
    end
    cfg_vld = 1'b0;
    chk("run_end", done, 1);
  endtask

  task automatic bad_cfg(input string tag, input int lanes, input int ha, input int hb,
                         input int va);
    cfg_lane_count  = 4'(lanes);
    cfg_tu_vld_int  = 7'd10;
    cfg_tu_vld_frac = FRAC_W'(17);
    cfg_h_active    = CTR_W'(ha);
    cfg_h_blank     = CTR_W'(hb);
    cfg_v_active    = CTR_W'(va);
    cfg_v_blank     = CTR_W'(1);
    cfg_vld = 1'b1;
    @(posedge clk); #1;
    cfg_vld = 1'b0;
    chk({tag, "_errpulse"}, cfg_err, 1);
    chk({tag, "_state"},    sched_state, 0);
    chk({tag, "_stream"},   sched_stream_en, 0);
    chk({tag, "_stuff"},    sched_stuff_en, 0);
    chk({tag, "_blank"},    sched_blank_en, 0);
    @(posedge clk); #1;
    check_idle(tag);
  endtask

  initial begin
    int s, f;
    int lanes, ha, hb, va, vb;
    rst = 1'b1; cfg_vld = 1'b0; stop = 1'b0;
    cfg_lane_count = '0; cfg_tu_vld_int = '0; cfg_tu_vld_frac = '0;
    cfg_h_active = '0; cfg_h_blank = '0; cfg_v_active = '0; cfg_v_blank = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // TU valid counts 40,41,40,41 on a 256-symbol line
    run(4, 40, 128, 256, 8, 1, 0, 10, -1, s, f);
    chk("tu_stream_cnt", s, 162);
    chk("tu_stuff_cnt", f, 94);

    // Saturated first TU, truncated second TU
    run(2, 70, 37, 100, 3, 1, 1, 5, -1, s, f);
    chk("sat_stream_cnt", s, 100);
    chk("sat_stuff_cnt", f, 0);

    // Small frame; stop lands on the frame-end slot
    run(1, 3, 200, 8, 4, 2, 1, 35, -1, s, f);

    bad_cfg("lanes3", 3, 8, 4, 1);
    bad_cfg("hblank1", 4, 8, 1, 1);
    bad_cfg("vact0", 2, 8, 4, 0);
    bad_cfg("hact0", 1, 0, 4, 1);
    bad_cfg("lanes8", 8, 8, 4, 1);

    // No vertical blanking, stop during the second frame
    run(4, 5, 100, 20, 3, 2, 0, 60, -1, s, f);

    // Reset in the middle of an active line, then restart with the same config
    run(2, 10, 200, 150, 4, 2, 1, -1, 100, s, f);
    run(2, 10, 200, 150, 4, 2, 1, 3, -1, s, f);

    for (int i = 0; i < 8; i++) begin
      lanes = 1 << $urandom_range(0, 2);
      ha = $urandom_range(1, 140);
      hb = $urandom_range(2, 9);
      va = $urandom_range(1, 3);
      vb = $urandom_range(0, 2);
      run(lanes, $urandom_range(0, 70), $urandom_range(0, 255), ha, hb, va, vb,
          $urandom_range(0, 2 * (va + vb) * (ha + hb) - 1), -1, s, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
